fb_rect_writer: RTL
===================

Name: fb_rect_writer

Overview:
Write-side engine for the 640x480, 8-bit-per-pixel Frame_Buffer; the frame_displayer is the read side. It accepts draw commands from the NIOS hardware ports through a valid/ready handshake. Each command is either a rectangle fill or a full-screen clear. It streams one pixel write per Clk into the frame buffer's data/wraddress/wren inputs, and replaces the tied-high frame_we.

Parameters:
H_RES, 640, visible columns
V_RES, 480, visible rows
ADDR_W, 19, frame buffer address width
SYNC_TO_VBLANK, 0, 1 = hold the first write of each command until vblank is high

Ports:
Clk  input  1  system clock (CLOCK_50)
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  1  0 = FILL_RECT, 1 = CLEAR
cmd_x  input  10  left column
cmd_y  input  10  top row
cmd_w  input  10  width in pixels
cmd_h  input  10  height in pixels
cmd_color  input  8  pixel value
vblank  input  1  vertical blank indicator (used only when SYNC_TO_VBLANK=1)
wr_addr  output  19  frame buffer write address
wr_data  output  8  frame buffer write data
wr_en  output  1  frame buffer write enable
busy  output  1  command in progress
done  output  1  one-cycle pulse at command completion

Behaviour:
- Clock and reset: one clock, Clk; reset is synchronous and active-high.
- Reset values: state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, cmd_ready=1.
- States: IDLE, LOAD, WAIT_VB, WRITE, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - Accept when cmd_valid && cmd_ready (cycle T); latch all cmd fields.
  - Next state is LOAD.
- LOAD (T+1):
  - CLEAR forces x0=0, y0=0, x1=H_RES, y1=V_RES.
  - FILL_RECT clips: x1=min(x+w, H_RES), y1=min(y+h, V_RES), computed at 11 bits with no wrap.
  - Empty region if x>=H_RES, y>=V_RES, w==0 or h==0: go to DONE with no writes.
  - Otherwise row_base = y0*640, computed as (y0<<9)+(y0<<7) with no multiplier; col=x0, row=y0.
  - Next state is WAIT_VB if SYNC_TO_VBLANK, else WRITE.
- WAIT_VB: stay until vblank=1, then WRITE.
- WRITE:
  - Each cycle: wr_en=1, wr_addr=row_base+col, wr_data=color.
  - col increments; at col==x1-1: col=x0, row++, row_base+=H_RES.
  - After the write at (x1-1, y1-1): DONE.
  - Outputs are registered, so the first wr_en is seen at T+2 when SYNC_TO_VBLANK=0.
  - Throughput is 1 pixel/cycle; wr_en never drops mid-command.
- DONE: done=1 for exactly one cycle, wr_en=0, then IDLE.
- cmd_ready=0 in every state except IDLE. cmd_valid while busy is ignored, not queued; the NIOS holds it until ready.
- Back-to-back commands: the next command can be accepted in the IDLE cycle after DONE.
- busy=1 in LOAD, WAIT_VB, WRITE and DONE.
- Reset mid-command: abort; wr_en=0 on the next cycle; no done pulse.
- wr_addr never exceeds H_RES*V_RES-1 (307199).

Decomposition:
- Package veggie_pkg:
  - H_RES, V_RES, FB_ADDR_W and FB_PIXELS constants.
  - typedef pixel_t (logic [7:0]).
  - enum draw_op_e {FILL_RECT, CLEAR}.
  - enum wr_state_e.
- No sub-module is required. The clip/row_base computation may be split into fb_rect_clip (combinational) if it aids reuse.

Test Plan:
- Reset held 2 cycles -> wr_en=0, busy=0, done=0, cmd_ready=1.
- FILL_RECT x=10 y=2 w=3 h=2 color=A5 -> wr_addr sequence 1290,1291,1292,1930,1931,1932 with wr_data=A5. First write at T+2. done pulses one cycle after the last write. Exactly 6 wr_en cycles.
- FILL_RECT x=638 y=479 w=5 h=5 -> clipped to 2 writes at 307198 and 307199, then done.
- FILL_RECT w=0 (and separately x=700) -> zero wr_en cycles; done pulses at T+2.
- CLEAR color=00 -> 307200 consecutive writes, addresses 0..307199, data 00, then done. cmd_valid pulsed with a different command mid-clear is ignored and cmd_ready stays 0.
- Reset asserted during the 4th write of a 3x3 fill -> wr_en=0 the next cycle, no done, cmd_ready=1. A following command executes normally.

Source files
------------

// File: rtl/veggie_pkg.sv
// veggie_pkg: shared frame-buffer geometry, pixel type and draw-engine enums
package veggie_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int FB_ADDR_W = 19;
  localparam int FB_PIXELS = H_RES * V_RES;
  typedef logic [7:0] pixel_t;
  typedef enum logic {FILL_RECT, CLEAR} draw_op_e;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_VB, WRITE, DONE} wr_state_e;
endpackage

// File: rtl/fb_rect_clip.sv
// fb_rect_clip: clips a draw command to the screen and derives the first row's base address
module fb_rect_clip #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ADDR_W = 19
) (
  input  logic              op_i,
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  input  logic [9:0]        w_i,
  input  logic [9:0]        h_i,
  output logic [9:0]        x0_o,
  output logic [9:0]        y0_o,
  output logic [10:0]       x1_o,
  output logic [10:0]       y1_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] row_base_o
);
  import veggie_pkg::*;
  logic clr;
  logic [10:0] xe, ye;
  assign clr = draw_op_e'(op_i) == CLEAR;
  assign xe = {1'b0, x_i} + {1'b0, w_i};
  assign ye = {1'b0, y_i} + {1'b0, h_i};
  assign x0_o = clr ? '0 : x_i;
  assign y0_o = clr ? '0 : y_i;
  assign x1_o = clr || xe > 11'(H_RES) ? 11'(H_RES) : xe;
  assign y1_o = clr || ye > 11'(V_RES) ? 11'(V_RES) : ye;
  assign empty_o = !clr && ({1'b0, x_i} >= 11'(H_RES) || {1'b0, y_i} >= 11'(V_RES) || w_i == '0 || h_i == '0);
  // y*640 as y*512 + y*128, no multiplier
  assign row_base_o = (ADDR_W'(y0_o) << 9) + (ADDR_W'(y0_o) << 7);
endmodule

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: streams one frame-buffer pixel write per clock for rectangle fills and full clears
module fb_rect_writer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ADDR_W = 19,
  parameter bit SYNC_TO_VBLANK = 1'b0
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [9:0]        cmd_x,
  input  logic [9:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [9:0]        cmd_h,
  input  logic [7:0]        cmd_color,
  input  logic              vblank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);
  import veggie_pkg::*;
  wr_state_e state_q, state_d;
  logic op_q;
  logic [9:0] x_q, y_q, w_q, h_q, x0_q, col_q, row_q, x0, y0;
  logic [10:0] x1_q, y1_q, x1, y1;
  logic [ADDR_W-1:0] row_base_q, row_base, wr_addr_q;
  pixel_t color_q, wr_data_q;
  logic wr_en_q, done_q, empty, col_end, last;
  fb_rect_clip #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_clip (
    .op_i(op_q), .x_i(x_q), .y_i(y_q), .w_i(w_q), .h_i(h_q),
    .x0_o(x0), .y0_o(y0), .x1_o(x1), .y1_o(y1), .empty_o(empty), .row_base_o(row_base)
  );
  assign col_end = {1'b0, col_q} + 11'd1 == x1_q;
  assign last = col_end && {1'b0, row_q} + 11'd1 == y1_q;
  always_ff @(posedge Clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cmd_valid ? LOAD : IDLE;
      LOAD:    state_d = empty ? DONE : (SYNC_TO_VBLANK ? WAIT_VB : WRITE);
      WAIT_VB: state_d = vblank ? WRITE : WAIT_VB;
      WRITE:   state_d = last ? DONE : WRITE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = state_q == IDLE;
    busy = state_q != IDLE;
  end
  always_ff @(posedge Clk) begin
    if (state_q == IDLE && cmd_valid) begin
      op_q <= cmd_op;
      x_q <= cmd_x;
      y_q <= cmd_y;
      w_q <= cmd_w;
      h_q <= cmd_h;
      color_q <= cmd_color;
    end
    if (state_q == LOAD) begin
      x0_q <= x0;
      x1_q <= x1;
      y1_q <= y1;
      col_q <= x0;
      row_q <= y0;
      row_base_q <= row_base;
    end else if (state_q == WRITE) begin
      col_q <= col_end ? x0_q : col_q + 10'd1;
      if (col_end) begin
        row_q <= row_q + 10'd1;
        row_base_q <= row_base_q + ADDR_W'(H_RES);
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q <= 1'b0;
    end else begin
      wr_en_q <= state_q == WRITE;
      done_q <= state_q == DONE;
      if (state_q == WRITE) begin
        wr_addr_q <= row_base_q + ADDR_W'(col_q);
        wr_data_q <= color_q;
      end
    end
  end
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done = done_q;
endmodule
